approx_mul_err_monitor: RTL and testbench

Synthesizable receiving end of the 8x8 approximate-multiplier characterization flow. It accepts (a, b, Y) samples from any approximate multiplier under test over a valid/ready handshake and computes the exact product internally. It accumulates exact-match count, sum of absolute error distance, and worst-case error with its operands. Results feed the on-chip accuracy report, replacing simulation-only checking.

---
 rtl/approx_mul_err_monitor.sv | 156 +++++++++++++++
 tb/tb_approx_mul_err_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_monitor.sv
// Accuracy monitor for an 8x8 approximate multiplier: takes (a, b, y) samples, compares
// them against the exact product, and accumulates match count, error sum and worst error.
module approx_mul_err_monitor #(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int SUM_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] match_count,
  output logic [SUM_W-1:0] err_sum,
  output logic [15:0]      max_err,
  output logic [7:0]       max_err_a,
  output logic [7:0]       max_err_b
);
  localparam int STAGES = 2;
  localparam int AW     = ((SUM_W > 16) ? SUM_W : 16) + 1;
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_SAMPLES - 1);
  localparam logic [AW-1:0]    SUM_MAX = (AW'(1) << SUM_W) - AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
    logic [15:0] p;
  } s1_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] ed;
    logic        match;
  } s2_t;

  state_e            state_q, state_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0]  sample_count_q, sample_count_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;
  logic [SUM_W-1:0]  err_sum_q, err_sum_d;
  logic [15:0]       max_err_q, max_err_d;
  logic [7:0]        max_err_a_q, max_err_a_d;
  logic [7:0]        max_err_b_q, max_err_b_d;
  logic [AW-1:0]     sum_ext;
  logic              xfer;

  assign in_ready = (state_q == RUN) && (sample_count_q <= N_LAST);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  assign sample_count = sample_count_q;
  assign match_count  = match_count_q;
  assign err_sum      = err_sum_q;
  assign max_err      = max_err_q;
  assign max_err_a    = max_err_a_q;
  assign max_err_b    = max_err_b_q;

  always_comb begin
    state_d        = state_q;
    vld_pipe_d     = {vld_pipe_q[STAGES-1:0], xfer};
    sample_count_d = sample_count_q;
    match_count_d  = match_count_q;
    err_sum_d      = err_sum_q;
    max_err_d      = max_err_q;
    max_err_a_d    = max_err_a_q;
    max_err_b_d    = max_err_b_q;

    // Data registers load every cycle; only the valid bits decide what counts.
    s1_d.a     = a;
    s1_d.b     = b;
    s1_d.y     = y;
    s1_d.p     = 16'(a) * 16'(b);
    s2_d.a     = s1_q.a;
    s2_d.b     = s1_q.b;
    s2_d.ed    = (s1_q.y >= s1_q.p) ? (s1_q.y - s1_q.p) : (s1_q.p - s1_q.y);
    s2_d.match = (s1_q.y == s1_q.p);
    s3_d       = s2_q;

    sum_ext = AW'(err_sum_q) + AW'(s3_q.ed);
    if (vld_pipe_q[STAGES]) begin
      match_count_d = match_count_q + CNT_W'(s3_q.match);
      err_sum_d     = (sum_ext > SUM_MAX) ? SUM_W'(SUM_MAX) : SUM_W'(sum_ext);
      // Strict compare so ties keep the earliest operands.
      if (s3_q.ed > max_err_q) begin
        max_err_d   = s3_q.ed;
        max_err_a_d = s3_q.a;
        max_err_b_d = s3_q.b;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sample_count_d = '0;
          match_count_d  = '0;
          err_sum_d      = '0;
          max_err_d      = '0;
          max_err_a_d    = '0;
          max_err_b_d    = '0;
          state_d        = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          sample_count_d = sample_count_q + CNT_W'(1);
          if (sample_count_q == N_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_pipe_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      vld_pipe_q     <= '0;
      s1_q           <= '0;
      s2_q           <= '0;
      s3_q           <= '0;
      sample_count_q <= '0;
      match_count_q  <= '0;
      err_sum_q      <= '0;
      max_err_q      <= '0;
      max_err_a_q    <= '0;
      max_err_b_q    <= '0;
    end else begin
      state_q        <= state_d;
      vld_pipe_q     <= vld_pipe_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      sample_count_q <= sample_count_d;
      match_count_q  <= match_count_d;
      err_sum_q      <= err_sum_d;
      max_err_q      <= max_err_d;
      max_err_a_q    <= max_err_a_d;
      max_err_b_q    <= max_err_b_d;
    end
  end
endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Directed bench for approx_mul_err_monitor: several instances with different run lengths
// and accumulator widths share one stimulus bus; each test starts only its own instance.
module tb_approx_mul_err_monitor;
  localparam int ND = 5;

  logic        clk = 0;
  logic        rst = 1;
  logic [ND-1:0] start_v = '0;
  logic        in_valid = 0;
  logic [7:0]  a = 0, b = 0;
  logic [15:0] y = 0;

  logic        rdy[ND], bsy[ND], dn[ND];
  logic [16:0] sc[ND], mc[ND];
  logic [31:0] es[ND];
  logic [15:0] me[ND];
  logic [7:0]  ma[ND], mb[ND];

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  // 0: N=4, 1: N=3, 2: N=2, 3: N=65536, 4: N=2 with an 8-bit error sum
  for (genvar i = 0; i < ND; i++) begin : g_dut
    localparam int NS = (i == 0) ? 4 : (i == 1) ? 3 : (i == 2) ? 2 : (i == 3) ? 65536 : 2;
    localparam int SW = (i == 4) ? 8 : 32;
    logic [SW-1:0] es_w;
    approx_mul_err_monitor #(.N_SAMPLES(NS), .CNT_W(17), .SUM_W(SW)) u_dut (
      .clk(clk), .rst(rst), .start(start_v[i]), .in_valid(in_valid), .in_ready(rdy[i]),
      .a(a), .b(b), .y(y), .busy(bsy[i]), .done(dn[i]),
      .sample_count(sc[i]), .match_count(mc[i]), .err_sum(es_w),
      .max_err(me[i]), .max_err_a(ma[i]), .max_err_b(mb[i])
    );
    assign es[i] = 32'(es_w);
  end

  typedef struct {
    int          d;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
  } smp_t;

  typedef struct {
    int d; int first; int n;
    int sc; int mc; int es; int me; int ma; int mb;
  } row_t;

  smp_t st[17];
  row_t rt[5];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic pulse_start(int d);
    start_v[d] = 1'b1;
    tick();
    start_v = '0;
  endtask

  task automatic feed(int d, logic [7:0] fa, logic [7:0] fb, logic [15:0] fy);
    int g;
    g = 0;
    a = fa; b = fb; y = fy; in_valid = 1'b1;
    while (!rdy[d] && g < 20) begin tick(); g++; end
    check("feed_ready_timeout", 32'(rdy[d]), 32'd1);
    tick();
  endtask

  task automatic wait_done(int d, output int lat);
    lat = 0;
    do begin tick(); lat++; end while (!dn[d] && lat < 50);
  endtask

  initial begin
    int lat;
    st[0]  = '{0, 8'd3,   8'd5,   16'd15};
    st[1]  = '{0, 8'd0,   8'd9,   16'd0};
    st[2]  = '{0, 8'd255, 8'd255, 16'd65025};
    st[3]  = '{0, 8'd16,  8'd16,  16'd256};
    st[4]  = '{1, 8'd10,  8'd10,  16'd96};
    st[5]  = '{1, 8'd7,   8'd8,   16'd60};
    st[6]  = '{1, 8'd200, 8'd3,   16'd600};
    st[7]  = '{4, 8'd1,   8'd1,   16'd201};
    st[8]  = '{4, 8'd1,   8'd1,   16'd201};
    st[9]  = '{0, 8'd2,   8'd3,   16'd7};
    st[10] = '{0, 8'd255, 8'd255, 16'd0};
    st[11] = '{0, 8'd0,   8'd0,   16'd0};
    st[12] = '{0, 8'd255, 8'd255, 16'd0};
    st[13] = '{0, 8'd1,   8'd2,   16'd3};
    st[14] = '{0, 8'd4,   8'd4,   16'd10};
    st[15] = '{0, 8'd3,   8'd3,   16'd0};
    st[16] = '{0, 8'd9,   8'd9,   16'd81};
    //          d first n  sc mc  es      me     ma   mb
    rt[0] = '{0, 0,  4, 4, 4, 0,      0,     0,   0};
    rt[1] = '{1, 4,  3, 3, 1, 8,      4,     10,  10};
    rt[2] = '{4, 7,  2, 2, 0, 255,    200,   1,   1};
    rt[3] = '{0, 9,  4, 4, 1, 130051, 65025, 255, 255};
    rt[4] = '{0, 13, 4, 4, 1, 16,     9,     3,   3};

    tick(); tick();
    check("rst_ready", 32'(rdy[0]), 0);
    check("rst_busy",  32'(bsy[0]), 0);
    check("rst_done",  32'(dn[0]),  0);
    check("rst_sc",    32'(sc[0]),  0);
    check("rst_es",    es[0],       0);
    check("rst_me",    32'(me[0]),  0);
    rst = 0;
    tick();
    check("idle_ready", 32'(rdy[0]), 0);

    for (int r = 0; r < 5; r++) begin
      int d;
      d = rt[r].d;
      pulse_start(d);
      check($sformatf("row%0d_busy", r), 32'(bsy[d]), 1);
      for (int s = 0; s < rt[r].n; s++)
        feed(d, st[rt[r].first + s].a, st[rt[r].first + s].b, st[rt[r].first + s].y);
      in_valid = 0;
      wait_done(d, lat);
      check($sformatf("row%0d_done_latency", r), 32'(lat), 4);
      check($sformatf("row%0d_sc", r), 32'(sc[d]), 32'(rt[r].sc));
      check($sformatf("row%0d_mc", r), 32'(mc[d]), 32'(rt[r].mc));
      check($sformatf("row%0d_es", r), es[d],      32'(rt[r].es));
      check($sformatf("row%0d_me", r), 32'(me[d]), 32'(rt[r].me));
      check($sformatf("row%0d_ma", r), 32'(ma[d]), 32'(rt[r].ma));
      check($sformatf("row%0d_mb", r), 32'(mb[d]), 32'(rt[r].mb));
      check($sformatf("row%0d_busy_end", r), 32'(bsy[d]), 0);
    end

    // Handshake with gaps on the N=2 instance
    pulse_start(2);
    a = 3; b = 3; y = 9; in_valid = 1; tick();
    check("hs_sc_after_1", 32'(sc[2]), 1);
    in_valid = 0; tick();
    check("hs_sc_bubble", 32'(sc[2]), 1);
    a = 4; b = 4; y = 16; in_valid = 1; tick();
    check("hs_sc_after_2", 32'(sc[2]), 2);
    check("hs_ready_drop", 32'(rdy[2]), 0);
    tick();
    check("hs_sc_extra_ignored", 32'(sc[2]), 2);
    in_valid = 0;
    wait_done(2, lat);
    check("hs_done", 32'(dn[2]), 1);
    check("hs_mc", 32'(mc[2]), 2);

    // start mid-RUN is ignored
    pulse_start(0);
    feed(0, 8'd5, 8'd5, 16'd20);
    feed(0, 8'd2, 8'd2, 16'd4);
    in_valid = 0;
    repeat (4) tick();
    check("mid_es_before", es[0], 5);
    pulse_start(0);
    check("mid_es_after_start", es[0], 5);
    check("mid_sc_after_start", 32'(sc[0]), 2);
    check("mid_busy", 32'(bsy[0]), 1);
    feed(0, 8'd1, 8'd1, 16'd1);
    feed(0, 8'd1, 8'd1, 16'd1);
    in_valid = 0;
    wait_done(0, lat);
    check("mid_done", 32'(dn[0]), 1);
    check("mid_sc", 32'(sc[0]), 4);
    check("mid_mc", 32'(mc[0]), 3);
    check("mid_me", 32'(me[0]), 5);
    check("mid_ma", 32'(ma[0]), 5);

    // reset mid-RUN discards everything, including samples in flight
    pulse_start(0);
    feed(0, 8'd5, 8'd5, 16'd20);
    in_valid = 0;
    rst = 1; tick(); rst = 0;
    check("rstrun_sc", 32'(sc[0]), 0);
    check("rstrun_busy", 32'(bsy[0]), 0);
    check("rstrun_ready", 32'(rdy[0]), 0);
    check("rstrun_done", 32'(dn[0]), 0);
    repeat (4) tick();
    check("rstrun_es", es[0], 0);
    check("rstrun_me", 32'(me[0]), 0);
    check("rstrun_state_idle", 32'(bsy[0]) | 32'(dn[0]), 0);

    // Full sweep, single corrupted corner
    pulse_start(3);
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++) begin
        logic [15:0] pp;
        pp = (i == 255 && j == 255) ? 16'd0 : 16'(i * j);
        a = 8'(i); b = 8'(j); y = pp; in_valid = 1;
        if (!rdy[3]) begin
          total++;
          $display("FAIL sweep_ready: got 0 expected 1 at a=%0d b=%0d", i, j);
        end
        tick();
      end
    in_valid = 0;
    wait_done(3, lat);
    check("sweep_done_latency", 32'(lat), 4);
    check("sweep_sc", 32'(sc[3]), 65536);
    check("sweep_mc", 32'(mc[3]), 65535);
    check("sweep_es", es[3], 65025);
    check("sweep_me", 32'(me[3]), 65025);
    check("sweep_ma", 32'(ma[3]), 255);
    check("sweep_mb", 32'(mb[3]), 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
